// File: rtl/vlsu_pkg.sv
// Shared types for the matrix load/store units: sequential entry buffer,
// per-beat transaction control and the final-beat helper.
package vlsu_pkg;

    localparam int unsigned VlsuNrExits      = 4;
    localparam int unsigned VlsuDlen         = 64;
    localparam int unsigned VlsuAxiDataWidth = 128;
    localparam int unsigned VlsuAxiAddrWidth = 64;
    localparam int unsigned VlsuRmnBeatWidth = 8;
    localparam int unsigned VlsuLaneNbs      = (VlsuDlen / 4) * VlsuNrExits;
    localparam int unsigned VlsuBusNibbles   = VlsuAxiDataWidth / 4;
    localparam int unsigned VlsuBusNSize     = $clog2(VlsuBusNibbles);

    typedef struct packed {
        logic [4*VlsuLaneNbs-1:0] nb;
        logic [VlsuLaneNbs-1:0]   en;
    } seq_buf_t;

    typedef struct packed {
        logic [VlsuAxiAddrWidth-1:0] addr;
        logic                        is_head;
        logic [VlsuRmnBeatWidth-1:0] rmn_beat;
        logic [VlsuBusNSize:0]       lbn;
        logic                        is_final_txn;
    } txn_ctrl_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SERIAL = 2'd1,
        S_GATHER = 2'd2
    } seq_state_e;

    function automatic logic isFinalBeat(input txn_ctrl_t c);
        return c.is_final_txn && (c.rmn_beat == '0);
    endfunction

endpackage

// File: rtl/CircularQueuePtrTemplate.sv
// Flag+value circular queue pointer; the flag toggles on each wrap so that
// equal values distinguish full (flags differ) from empty (flags equal).
module CircularQueuePtrTemplate #(
    parameter  int unsigned ENTRIES = 2,
    localparam int unsigned PtrW    = (ENTRIES > 1) ? $clog2(ENTRIES) : 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            inc_i,
    output logic            flag_o,
    output logic [PtrW-1:0] value_o
);

    logic            flag_q, flag_d;
    logic [PtrW-1:0] value_q, value_d;

    always_comb begin
        flag_d  = flag_q;
        value_d = value_q;
        if (inc_i) begin
            if (value_q == PtrW'(ENTRIES - 1)) begin
                value_d = '0;
                flag_d  = ~flag_q;
            end else begin
                value_d = value_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            flag_q  <= 1'b0;
            value_q <= '0;
        end else begin
            flag_q  <= flag_d;
            value_q <= value_d;
        end
    end

    assign flag_o  = flag_q;
    assign value_o = value_q;

endmodule

// File: rtl/m_sequential_load.sv
// Matrix sequential load: extracts the valid nibble window of each AXI R beat
// and packs it contiguously into lane-entry buffers for the ShuffleUnit.
module m_sequential_load
    import vlsu_pkg::*;
#(
    parameter  int unsigned NrExits      = 4,
    parameter  int unsigned Dlen         = 64,
    parameter  int unsigned AxiDataWidth = 128,
    parameter  int unsigned AxiAddrWidth = 64,
    parameter  int unsigned RmnBeatWidth = 8,
    localparam int unsigned LaneNbs      = (Dlen / 4) * NrExits,
    localparam int unsigned busNibbles   = AxiDataWidth / 4,
    localparam int unsigned busNSize     = $clog2(busNibbles)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    axi_r_valid_i,
    output logic                    axi_r_ready_o,
    input  logic [AxiDataWidth-1:0] axi_r_data_i,
    input  logic                    axi_r_last_i,
    input  logic                    txn_ctrl_valid_i,
    output logic                    txn_ctrl_ready_o,
    input  logic [AxiAddrWidth-1:0] txn_addr_i,
    input  logic                    txn_is_head_i,
    input  logic [RmnBeatWidth-1:0] txn_rmn_beat_i,
    input  logic [busNSize:0]       txn_lbn_i,
    input  logic                    txn_is_final_txn_i,
    output logic                    tx_shfu_valid_o,
    input  logic                    tx_shfu_ready_i,
    output logic [4*LaneNbs-1:0]    tx_shfu_nb_o,
    output logic [LaneNbs-1:0]      tx_shfu_en_o
);

    localparam int unsigned BW = busNSize + 1;
    localparam int unsigned PW = $clog2(LaneNbs);
    localparam int unsigned SW = PW + 1;
    localparam int unsigned CW = (BW > SW) ? BW : SW;

    seq_state_e      state_q, state_d;
    logic [BW-1:0]   bus_nb_cnt_q, bus_nb_cnt_d;
    logic [PW-1:0]   seq_nb_ptr_q, seq_nb_ptr_d;
    seq_buf_t [1:0]  buf_q, buf_d;
    seq_buf_t        fill;

    txn_ctrl_t       ctrl;
    logic [BW-1:0]   lower, upper, bus_valid, start;
    logic [CW-1:0]   bv_ext, space_ext, ptr_ext, nr;
    logic            final_beat, commit, push, consume, pop;
    logic            enq_flag, deq_flag, enq_val, deq_val, empty, out_full;
    int unsigned     idx;

    always_comb begin
        ctrl.addr         = txn_addr_i;
        ctrl.is_head      = txn_is_head_i;
        ctrl.rmn_beat     = txn_rmn_beat_i;
        ctrl.lbn          = txn_lbn_i;
        ctrl.is_final_txn = txn_is_final_txn_i;
    end

    assign final_beat = isFinalBeat(ctrl);
    assign lower      = ctrl.is_head ? {1'b0, ctrl.addr[busNSize-1:0]} : '0;
    assign upper      = (ctrl.rmn_beat == '0) ? ctrl.lbn : BW'(busNibbles);
    assign bus_valid  = upper - lower - bus_nb_cnt_q;
    assign start      = lower + bus_nb_cnt_q;
    assign ptr_ext    = CW'(seq_nb_ptr_q);
    assign bv_ext     = CW'(bus_valid);
    assign space_ext  = CW'(LaneNbs) - ptr_ext;
    assign nr         = (bv_ext < space_ext) ? bv_ext : space_ext;

    assign empty    = (enq_flag == deq_flag) && (enq_val == deq_val);
    assign out_full = (enq_flag != deq_flag) && (enq_val == deq_val);
    assign commit   = (state_q == S_SERIAL) && axi_r_valid_i && txn_ctrl_valid_i && !out_full;
    assign pop      = !empty && tx_shfu_ready_i;

    // The entry under construction lives in the enqueue slot itself.
    always_comb begin
        fill = buf_q[enq_val];
        idx  = 0;
        for (int unsigned j = 0; j < LaneNbs; j++) begin
            if ((CW'(j) >= ptr_ext) && (CW'(j) < ptr_ext + nr)) begin
                idx = 32'(start) + j - 32'(seq_nb_ptr_q);
                fill.nb[4*j +: 4] = axi_r_data_i[4*idx[busNSize-1:0] +: 4];
                fill.en[j]        = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        bus_nb_cnt_d = bus_nb_cnt_q;
        seq_nb_ptr_d = seq_nb_ptr_q;
        push         = 1'b0;
        consume      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (txn_ctrl_valid_i) begin
                    state_d      = S_SERIAL;
                    bus_nb_cnt_d = '0;
                    seq_nb_ptr_d = '0;
                end
            end
            S_SERIAL: begin
                if (commit) begin
                    if (bv_ext > space_ext) begin
                        push         = 1'b1;
                        seq_nb_ptr_d = '0;
                        bus_nb_cnt_d = bus_nb_cnt_q + BW'(nr);
                    end else begin
                        consume      = 1'b1;
                        bus_nb_cnt_d = '0;
                        if ((bv_ext == space_ext) || final_beat) begin
                            push         = 1'b1;
                            seq_nb_ptr_d = '0;
                        end else begin
                            seq_nb_ptr_d = seq_nb_ptr_q + PW'(nr);
                        end
                        if (final_beat) begin
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        buf_d = buf_q;
        if (commit) begin
            buf_d[enq_val] = fill;
        end
        if (pop) begin
            buf_d[deq_val] = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            bus_nb_cnt_q <= '0;
            seq_nb_ptr_q <= '0;
            buf_q        <= '0;
        end else begin
            state_q      <= state_d;
            bus_nb_cnt_q <= bus_nb_cnt_d;
            seq_nb_ptr_q <= seq_nb_ptr_d;
            buf_q        <= buf_d;
        end
    end

    CircularQueuePtrTemplate #(.ENTRIES(2)) u_enq_ptr (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   (push),
        .flag_o  (enq_flag),
        .value_o (enq_val)
    );

    CircularQueuePtrTemplate #(.ENTRIES(2)) u_deq_ptr (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   (pop),
        .flag_o  (deq_flag),
        .value_o (deq_val)
    );

    assign axi_r_ready_o    = consume;
    assign txn_ctrl_ready_o = consume;
    assign tx_shfu_valid_o  = !empty;
    assign tx_shfu_nb_o     = empty ? '0 : buf_q[deq_val].nb;
    assign tx_shfu_en_o     = empty ? '0 : buf_q[deq_val].en;

    a_last_matches: assert property (@(posedge clk_i) disable iff (!rst_ni)
        consume |-> (axi_r_last_i == (ctrl.rmn_beat == '0)));

    a_window_ok: assert property (@(posedge clk_i) disable iff (!rst_ni)
        ((state_q == S_SERIAL) && txn_ctrl_valid_i) |->
        ((bus_valid <= BW'(busNibbles)) && (upper <= BW'(busNibbles)) && (ctrl.lbn != '0)));

endmodule

// File: tb/tb_m_sequential_load.sv
// Directed bench for m_sequential_load: table of single-request cases plus
// backpressure and mid-entry reset sequences.
module tb_m_sequential_load;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           r_valid, r_ready, r_last;
    logic [127:0]   r_data;
    logic           c_valid, c_ready;
    logic [63:0]    addr;
    logic           head, fin;
    logic [7:0]     rmn;
    logic [5:0]     lbn;
    logic           tx_valid, tx_ready;
    logic [255:0]   tx_nb;
    logic [63:0]    tx_en;

    always #5 clk = ~clk;

    m_sequential_load #(
        .NrExits      (4),
        .Dlen         (64),
        .AxiDataWidth (128),
        .AxiAddrWidth (64),
        .RmnBeatWidth (8)
    ) dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .axi_r_valid_i      (r_valid),
        .axi_r_ready_o      (r_ready),
        .axi_r_data_i       (r_data),
        .axi_r_last_i       (r_last),
        .txn_ctrl_valid_i   (c_valid),
        .txn_ctrl_ready_o   (c_ready),
        .txn_addr_i         (addr),
        .txn_is_head_i      (head),
        .txn_rmn_beat_i     (rmn),
        .txn_lbn_i          (lbn),
        .txn_is_final_txn_i (fin),
        .tx_shfu_valid_o    (tx_valid),
        .tx_shfu_ready_i    (tx_ready),
        .tx_shfu_nb_o       (tx_nb),
        .tx_shfu_en_o       (tx_en)
    );

    int n_cmp = 0;
    int n_err = 0;
    int beats_acc;
    int stalls [8];
    logic txv_pre, txv_post;

    logic [255:0] got_nb [$];
    logic [63:0]  got_en [$];

    always @(negedge clk) begin
        if (rst_n && tx_valid && tx_ready) begin
            got_nb.push_back(tx_nb);
            got_en.push_back(tx_en);
        end
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic send(input int nsend, input int rmn0, input logic [7:0][127:0] d,
                        input logic [4:0] alow, input logic [5:0] lbn_last, input logic f);
        int  st;
        bit  done;
        bit  tmo;
        for (int i = 0; i < nsend; i++) begin
            st     = 0;
            done   = 1'b0;
            tmo    = 1'b0;
            r_valid = 1'b1;
            c_valid = 1'b1;
            r_data  = d[i];
            addr    = {59'd0, alow};
            head    = (i == 0);
            rmn     = 8'(rmn0 - i);
            lbn     = ((rmn0 - i) == 0) ? lbn_last : 6'd32;
            r_last  = ((rmn0 - i) == 0);
            fin     = f;
            while (!done) begin
                @(negedge clk);
                if (r_ready) begin
                    done    = 1'b1;
                    txv_pre = tx_valid;
                end else begin
                    st++;
                end
                @(posedge clk);
                #1;
                if (done) txv_post = tx_valid;
                if (!done && st > 100) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL beat_timeout: beat %0d got no ready after %0d cycles, required ready", i, st);
                    done = 1'b1;
                    tmo  = 1'b1;
                end
            end
            stalls[i] = st;
            if (!tmo) beats_acc++;
        end
        r_valid = 1'b0;
        c_valid = 1'b0;
        r_last  = 1'b0;
        head    = 1'b0;
    endtask

    task automatic wait_got(input int n, input string name);
        int c = 0;
        while (got_nb.size() < n && c < 200) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk(name, got_nb.size(), n);
    endtask

    typedef struct {
        int               nbeats;
        logic [4:0]       alow;
        logic [5:0]       lbn;
        logic [7:0][127:0] d;
        int               ne;
        logic [1:0][255:0] enb;
        logic [1:0][63:0]  een;
    } case_t;

    case_t        cases [6];
    logic [127:0] pat [12];
    logic [255:0] e0, e1;
    logic [7:0][127:0] bp;

    initial begin
        pat[0]  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        pat[1]  = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        pat[2]  = 128'hA5A5_5A5A_C3C3_3C3C_0F0F_F0F0_1234_ABCD;
        pat[3]  = 128'hDEAD_BEEF_CAFE_BABE_0BAD_F00D_8BADF_00D;
        pat[4]  = 128'h4444_0000_4444_1111_4444_2222_4444_3333;
        pat[5]  = 128'h5555_AAAA_5555_BBBB_5555_CCCC_5555_DDDD;
        pat[6]  = 128'h6666_0123_6666_4567_6666_89AB_6666_CDEF;
        pat[7]  = 128'h7070_7171_7272_7373_7474_7575_7676_7777;
        pat[8]  = 128'h8080_8181_8282_8383_8484_8585_8686_8787;
        pat[9]  = 128'h9090_9191_9292_9393_9494_9595_9696_9797;
        pat[10] = 128'hA0A0_A1A1_A2A2_A3A3_A4A4_A5A5_A6A6_A7A7;
        pat[11] = 128'hB0B0_B1B1_B2B2_B3B3_B4B4_B5B5_B6B6_B7B7;

        for (int k = 0; k < 6; k++) begin
            cases[k].d   = '0;
            cases[k].enb = '0;
            cases[k].een = '0;
        end
        // aligned two full beats
        cases[0].nbeats = 2; cases[0].alow = 5'd0; cases[0].lbn = 6'd32; cases[0].ne = 1;
        cases[0].d[0] = pat[0]; cases[0].d[1] = pat[1];
        cases[0].enb[0] = {pat[1], pat[0]}; cases[0].een[0] = '1;
        // head offset 8, single beat
        cases[1].nbeats = 1; cases[1].alow = 5'd8; cases[1].lbn = 6'd32; cases[1].ne = 1;
        cases[1].d[0] = pat[2];
        e0 = '0; e0[95:0] = pat[2][127:32];
        cases[1].enb[0] = e0; cases[1].een[0] = 64'h0000_0000_00FF_FFFF;
        // partial last beat, lbn 5
        cases[2].nbeats = 1; cases[2].alow = 5'd0; cases[2].lbn = 6'd5; cases[2].ne = 1;
        cases[2].d[0] = pat[3];
        e0 = '0; e0[19:0] = pat[3][19:0];
        cases[2].enb[0] = e0; cases[2].een[0] = 64'h1F;
        // ptr reaches 48, then a full beat splits across two entries
        cases[3].nbeats = 3; cases[3].alow = 5'd16; cases[3].lbn = 6'd32; cases[3].ne = 2;
        cases[3].d[0] = pat[4]; cases[3].d[1] = pat[5]; cases[3].d[2] = pat[6];
        e0 = '0; e0[63:0] = pat[4][127:64]; e0[191:64] = pat[5]; e0[255:192] = pat[6][63:0];
        e1 = '0; e1[63:0] = pat[6][127:64];
        cases[3].enb[0] = e0; cases[3].een[0] = '1;
        cases[3].enb[1] = e1; cases[3].een[1] = 64'hFFFF;
        // head offset 4 with partial last beat lbn 16
        cases[4].nbeats = 2; cases[4].alow = 5'd4; cases[4].lbn = 6'd16; cases[4].ne = 1;
        cases[4].d[0] = pat[7]; cases[4].d[1] = pat[8];
        e0 = '0; e0[111:0] = pat[7][127:16]; e0[175:112] = pat[8][63:0];
        cases[4].enb[0] = e0; cases[4].een[0] = 64'h0000_0FFF_FFFF_FFFF;
        // exact fill on a non-final beat, then a short final beat
        cases[5].nbeats = 3; cases[5].alow = 5'd0; cases[5].lbn = 6'd8; cases[5].ne = 2;
        cases[5].d[0] = pat[9]; cases[5].d[1] = pat[10]; cases[5].d[2] = pat[11];
        e1 = '0; e1[31:0] = pat[11][31:0];
        cases[5].enb[0] = {pat[10], pat[9]}; cases[5].een[0] = '1;
        cases[5].enb[1] = e1; cases[5].een[1] = 64'hFF;

        rst_n = 1'b0; r_valid = 1'b0; c_valid = 1'b0; r_last = 1'b0; r_data = '0;
        addr = '0; head = 1'b0; fin = 1'b0; rmn = '0; lbn = 6'd32; tx_ready = 1'b1;
        beats_acc = 0;
        #1;
        chk("rst_r_ready", r_ready, 0);
        chk("rst_c_ready", c_ready, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_nb", tx_nb, 0);
        chk("rst_tx_en", tx_en, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int k = 0; k < 6; k++) begin
            got_nb.delete();
            got_en.delete();
            send(cases[k].nbeats, cases[k].nbeats - 1, cases[k].d, cases[k].alow, cases[k].lbn, 1'b1);
            chk($sformatf("c%0d_first_stall", k), stalls[0], 1);
            if (k == 0) begin
                chk("c0_valid_before_push", txv_pre, 0);
                chk("c0_valid_after_push", txv_post, 1);
            end
            if (k == 3) begin
                chk("c3_beat1_stall", stalls[1], 0);
                chk("c3_split_stall", stalls[2], 1);
            end
            wait_got(cases[k].ne, $sformatf("c%0d_count", k));
            for (int e = 0; e < cases[k].ne; e++) begin
                if (e < got_nb.size()) begin
                    chk($sformatf("c%0d_e%0d_nb", k, e), got_nb[e], cases[k].enb[e]);
                    chk($sformatf("c%0d_e%0d_en", k, e), got_en[e], cases[k].een[e]);
                end
            end
            repeat (3) @(posedge clk);
            #1;
            chk($sformatf("c%0d_drained", k), tx_valid, 0);
        end

        // backpressure: 8 full beats = 4 entries, sink stalled
        for (int i = 0; i < 8; i++) bp[i] = {32'hB000_0000 + i, 32'hC100_0000 + i, 32'hD200_0000 + i, 32'hE300_0000 + i};
        got_nb.delete();
        got_en.delete();
        tx_ready  = 1'b0;
        beats_acc = 0;
        fork
            send(8, 7, bp, 5'd0, 6'd32, 1'b1);
            begin
                repeat (30) @(posedge clk);
                #1;
                chk("bp_beats_accepted", beats_acc, 4);
                chk("bp_tx_valid", tx_valid, 1);
                chk("bp_r_ready_held", r_ready, 0);
                chk("bp_nothing_out", got_nb.size(), 0);
                tx_ready = 1'b1;
            end
        join
        wait_got(4, "bp_count");
        for (int i = 0; i < 4; i++) begin
            if (i < got_nb.size()) begin
                chk($sformatf("bp_e%0d_nb", i), got_nb[i], {bp[2*i+1], bp[2*i]});
                chk($sformatf("bp_e%0d_en", i), got_en[i], {64{1'b1}});
            end
        end

        // reset while an entry is half built (ptr 20) and another is buffered
        repeat (3) @(posedge clk);
        #1;
        got_nb.delete();
        got_en.delete();
        tx_ready = 1'b0;
        bp[0] = pat[0]; bp[1] = pat[1]; bp[2] = pat[2];
        send(3, 3, bp, 5'd12, 6'd32, 1'b1);
        chk("rm_buffered_valid", tx_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rm_r_ready", r_ready, 0);
        chk("rm_c_ready", c_ready, 0);
        chk("rm_tx_valid", tx_valid, 0);
        chk("rm_tx_nb", tx_nb, 0);
        chk("rm_tx_en", tx_en, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rm_quiet_after", tx_valid, 0);
        bp[0] = pat[5];
        send(1, 0, bp, 5'd0, 6'd32, 1'b1);
        wait_got(1, "rm_next_count");
        if (got_nb.size() > 0) begin
            e0 = '0; e0[127:0] = pat[5];
            chk("rm_next_nb", got_nb[0], e0);
            chk("rm_next_en", got_en[0], 64'h0000_0000_FFFF_FFFF);
        end

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
